data_source: RTL and testbench
==============================

Name: data_source

Overview:
- AXI4-Stream master: the transmit-side counterpart of the stream sink.
- Holds a preloadable register-file of payload words and, on START, streams a burst of LENGTH beats out of AXIS_PORT with tlast on the final beat.
- Used as a stimulus generator in front of stream consumers in design examples and benches.
- Loads through a simple write port; reports status through BUSY and DONE.

Parameters:
- DATA_WIDTH, 32: tdata width and payload word width.
- RAM_DEPTH, 64: number of payload words; power of two, at least 2.

Ports:
- ACLK  in  1  clock, all logic on rising edge.
- ARESETN  in  1  asynchronous, active-low reset.
- AXIS_PORT  axi4s_if.master  interface  drives tvalid, tdata[DATA_WIDTH-1:0], tlast; samples tready.
- START  in  1  single-cycle pulse that launches a burst; sampled only in IDLE.
- LENGTH  in  $clog2(RAM_DEPTH)+1  beats per burst; captured when START is accepted.
- WR_EN  in  1  payload write strobe.
- WR_ADDR  in  $clog2(RAM_DEPTH)  payload write address.
- WR_DATA  in  DATA_WIDTH  payload write data.
- BUSY  out  1  high while in RUN.
- DONE  out  1  one-cycle pulse after the last beat handshakes.

Behaviour:
- Reset (async assert, sync release): state=IDLE; tvalid=0, tlast=0, tdata=0, BUSY=0, DONE=0, beat index=0. Payload array is not reset; it initialises to 0 at time zero.
- FSM states: IDLE, RUN.
- IDLE -> RUN on START && LENGTH!=0:
  - len_q <= min(LENGTH, RAM_DEPTH); idx <= 0.
  - tdata <= ram[0]; tvalid <= 1; tlast <= (len_q==1).
  - tvalid is high on the cycle after START is sampled (latency 1).
- START with LENGTH==0: ignored; stay IDLE, no DONE.
- RUN, on handshake (tvalid && tready):
  - If tlast: tvalid <= 0, tlast <= 0, DONE <= 1 for one cycle, go to IDLE.
  - Otherwise: idx <= idx+1; tdata <= ram[idx+1]; tlast <= (idx+2 == len_q).
  - Throughput is 1 beat/cycle when tready is held high.
- RUN, no handshake: tvalid, tdata and tlast held stable. tvalid never deasserts before its handshake (AXI4-Stream rule). tvalid never depends combinationally on tready.
- START while in RUN: ignored.
- A new START in the same cycle DONE pulses is ignored. START is accepted from the following cycle.
- Payload writes:
  - Accepted in IDLE: ram[WR_ADDR] <= WR_DATA.
  - Dropped while BUSY, so the payload is frozen during a burst.
  - A write in the same cycle as START is accepted; the burst reads the old word at that address only if the address is 0.
- Index width: idx is $clog2(RAM_DEPTH) bits. len_q==RAM_DEPTH ends at idx=RAM_DEPTH-1 with no wrap.
- Reset mid-burst: tvalid drops asynchronously, no DONE, payload retained.
- BUSY = (state==RUN).

Optional Feature:
- Macro DATA_SOURCE_PRBS_EN.
- When defined:
  - Payload comes from a DATA_WIDTH-bit Galois LFSR instead of the array; the write port still writes the array but does not affect output.
  - Seed = 1 on reset and at every START; taps come from the package.
  - The LFSR advances exactly once per handshake; tdata of beat k = LFSR state after k advances.
- When undefined: array-based payload as above; no LFSR logic is synthesised.

Decomposition:
- axi4_pkg gets:
  - typedef ds_state_t {IDLE, RUN};
  - localparam PRBS_TAPS_32 = 32'h8020_0003;
  - function clog2-safe length clamp.
- One sub-module, data_source_ram: RAM_DEPTH x DATA_WIDTH flop array with a synchronous write port and an asynchronous read port (read address idx or idx+1). Instantiated only when DATA_SOURCE_PRBS_EN is undefined or for the write path.

Test Plan:
- Load ram[i]=i+100 for i=0..3, START with LENGTH=4, tready=1 -> beats 100,101,102,103 on consecutive cycles; tlast only on 103; DONE pulses 1 cycle after the 103 handshake.
- Same burst with tready toggling 1,0,0,1,... -> tvalid never drops; tdata and tlast stable through the stalls; same 4 values in order.
- START with LENGTH=0 -> tvalid stays 0, BUSY=0, no DONE. START with LENGTH=RAM_DEPTH+? beyond range (LENGTH=127 with RAM_DEPTH=64) -> exactly 64 beats, tlast on ram[63].
- During a burst, write ram[1]=0xDEAD -> ignored; a rerun streams the old value. START during RUN -> no effect on beat count.
- Assert ARESETN=0 mid-burst after 2 beats -> tvalid=0 immediately, no DONE; the next START streams from ram[0].
- With DATA_SOURCE_PRBS_EN, LENGTH=3 -> tdata=1, then LFSR(1), then LFSR(LFSR(1)); a second START restarts from 1.

Source files
------------

// File: rtl/axi4_pkg.sv
// Shared types and constants for the AXI4-Stream data source.
// Contents: FSM state type, PRBS tap mask, burst length clamp helper.
package axi4_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ds_state_t;

  // Galois LFSR tap mask for a 32-bit PRBS (right-shifting form).
  localparam logic [31:0] PRBS_TAPS_32 = 32'h8020_0003;

  // Limit a requested burst length to the number of payload words.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
    return (len > depth) ? depth : len;
  endfunction

endpackage

// File: rtl/axi4s_if.sv
// AXI4-Stream interface bundle (tvalid/tready/tdata/tlast).
// Modports: master drives tvalid/tdata/tlast and samples tready; slave is the mirror.
interface axi4s_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/data_source_ram.sv
// Payload store: RAM_DEPTH x DATA_WIDTH flop array, synchronous write, asynchronous read.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_addr -> rd_data combinational read.
// Contents are intentionally not reset.
module data_source_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RAM_DEPTH  = 64
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [$clog2(RAM_DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic [$clog2(RAM_DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]        rd_data
);

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/data_source.sv
// AXI4-Stream burst generator: on START streams LENGTH (clamped to RAM_DEPTH) payload
// beats out of AXIS_PORT, tlast on the final beat, DONE pulse after it handshakes.
// Ports: ACLK, ARESETN (async active-low); AXIS_PORT (axi4s_if.master);
//        START/LENGTH burst launch; WR_EN/WR_ADDR/WR_DATA payload load (IDLE only);
//        BUSY (in RUN), DONE (one-cycle pulse).
// Build option: define DATA_SOURCE_PRBS_EN to source payload from a Galois LFSR
// (seed 1 at reset and every START) instead of the payload array.
module data_source
  import axi4_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RAM_DEPTH  = 64
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  axi4s_if.master                      AXIS_PORT,
  input  logic                         START,
  input  logic [$clog2(RAM_DEPTH):0]   LENGTH,
  input  logic                         WR_EN,
  input  logic [$clog2(RAM_DEPTH)-1:0] WR_ADDR,
  input  logic [DATA_WIDTH-1:0]        WR_DATA,
  output logic                         BUSY,
  output logic                         DONE
);

  localparam int unsigned AW = $clog2(RAM_DEPTH);
  localparam int unsigned LW = AW + 1;

  ds_state_t             state_q;
  logic [AW-1:0]         idx_q;
  logic [LW-1:0]         len_q;
  logic                  tvalid_q;
  logic                  tlast_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  done_q;

  logic [LW-1:0]         len_clamp_c;
  logic                  start_accept_c;
  logic                  hs_c;
  logic [AW-1:0]         ram_raddr_c;
  logic [DATA_WIDTH-1:0] ram_rdata_c;
  logic [DATA_WIDTH-1:0] first_word_c;
  logic [DATA_WIDTH-1:0] next_word_c;

  assign len_clamp_c = LW'(clamp_len(32'(LENGTH), RAM_DEPTH));
  // START is ignored in the DONE cycle so back-to-back launches see a clean gap.
  assign start_accept_c = (state_q == IDLE) && START && !done_q && (LENGTH != '0);
  assign hs_c           = (state_q == RUN) && tvalid_q && AXIS_PORT.tready;
  // IDLE prefetches word 0 for launch; RUN prefetches the word after the current beat.
  assign ram_raddr_c    = (state_q == RUN) ? idx_q + AW'(1) : '0;

  // Payload is frozen during a burst: writes only land while IDLE.
  data_source_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .RAM_DEPTH  (RAM_DEPTH)
  ) u_ram (
    .clk     (ACLK),
    .wr_en   (WR_EN && (state_q == IDLE)),
    .wr_addr (WR_ADDR),
    .wr_data (WR_DATA),
    .rd_addr (ram_raddr_c),
    .rd_data (ram_rdata_c)
  );

`ifdef DATA_SOURCE_PRBS_EN
  localparam logic [DATA_WIDTH-1:0] PRBS_TAPS = DATA_WIDTH'(PRBS_TAPS_32);

  logic [DATA_WIDTH-1:0] lfsr_q;

  function automatic logic [DATA_WIDTH-1:0] lfsr_step(input logic [DATA_WIDTH-1:0] s);
    return (s >> 1) ^ (s[0] ? PRBS_TAPS : '0);
  endfunction

  // LFSR reseeds on launch and advances once per handshake.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)            lfsr_q <= DATA_WIDTH'(1);
    else if (start_accept_c) lfsr_q <= DATA_WIDTH'(1);
    else if (hs_c)           lfsr_q <= lfsr_step(lfsr_q);
  end

  assign first_word_c = DATA_WIDTH'(1);
  assign next_word_c  = lfsr_step(lfsr_q);
`else
  assign first_word_c = ram_rdata_c;
  assign next_word_c  = ram_rdata_c;
`endif

  // Burst FSM with registered stream outputs.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_accept_c) begin
            state_q  <= RUN;
            len_q    <= len_clamp_c;
            idx_q    <= '0;
            tdata_q  <= first_word_c;
            tvalid_q <= 1'b1;
            tlast_q  <= (len_clamp_c == LW'(1));
          end
        end
        RUN: begin
          if (hs_c) begin
            if (tlast_q) begin
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= IDLE;
            end else begin
              idx_q   <= idx_q + AW'(1);
              tdata_q <= next_word_c;
              tlast_q <= (LW'(idx_q) + LW'(2) == len_q);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign AXIS_PORT.tvalid = tvalid_q;
  assign AXIS_PORT.tdata  = tdata_q;
  assign AXIS_PORT.tlast  = tlast_q;
  assign BUSY             = (state_q == RUN);
  assign DONE             = done_q;

endmodule

// File: tb/tb_data_source.sv
// Bench for data_source: directed scenarios plus randomized bursts, checked against
// a payload-array / PRBS-sequence model kept in the bench.
module tb_data_source;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic          ACLK = 1'b0;
  logic          ARESETN;
  logic          START;
  logic [AW:0]   LENGTH;
  logic          WR_EN;
  logic [AW-1:0] WR_ADDR;
  logic [DW-1:0] WR_DATA;
  logic          BUSY;
  logic          DONE;

  axi4s_if #(.DATA_WIDTH(DW)) axis ();

  data_source #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH)) dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .AXIS_PORT (axis),
    .START     (START),
    .LENGTH    (LENGTH),
    .WR_EN     (WR_EN),
    .WR_ADDR   (WR_ADDR),
    .WR_DATA   (WR_DATA),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  always #5 ACLK = ~ACLK;

  int unsigned   n_pass  = 0;
  int unsigned   n_total = 0;
  logic [DW-1:0] model_ram [DEPTH];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Reference PRBS: right-shifting Galois LFSR with mask 0x80200003.
  function automatic logic [31:0] prbs_next(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 32'h8020_0003;
    return n;
  endfunction

  task automatic write_word(input int addr, input logic [DW-1:0] data);
    WR_EN = 1'b1; WR_ADDR = AW'(addr); WR_DATA = data;
    tick();
    WR_EN = 1'b0;
    model_ram[addr] = data;
  endtask

  // mode: 0 = tready held high, 1 = tready 1,0,0 repeating, 2 = random tready.
  task automatic run_burst(input int len_in, input int mode, input bit wr_mid, input bit start_mid,
                           input bit start_in_done, input bit wr_with_start,
                           input int wa, input logic [DW-1:0] wd);
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] hold_d;
    logic          hold_l;
    logic          rdy;
    int            n, k, cyc;
    logic [31:0]   p;
    n = (len_in > int'(DEPTH)) ? int'(DEPTH) : len_in;
    p = 32'd1;
    for (int i = 0; i < n; i++) begin
`ifdef DATA_SOURCE_PRBS_EN
      exp_q.push_back(p);
      p = prbs_next(p);
`else
      exp_q.push_back(model_ram[i]);
`endif
    end
    START = 1'b1; LENGTH = (AW+1)'(len_in);
    if (wr_with_start) begin
      WR_EN = 1'b1; WR_ADDR = AW'(wa); WR_DATA = wd;
      model_ram[wa] = wd;
`ifndef DATA_SOURCE_PRBS_EN
      // Word 0 is already fetched at launch; later words see the new value.
      if (wa != 0 && wa < n) exp_q[wa] = wd;
`endif
    end
    tick();
    START = 1'b0; WR_EN = 1'b0;
    check("launch_busy", BUSY, 1);
    k = 0; cyc = 0;
    while (k < n && cyc < 1000) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (wr_mid && cyc == 1) begin
        WR_EN = 1'b1; WR_ADDR = AW'(1); WR_DATA = 32'hDEAD;
      end
      if (start_mid && cyc == 2) begin
        START = 1'b1; LENGTH = (AW+1)'(2);
      end
      axis.tready = rdy;
      hold_d = axis.tdata;
      hold_l = axis.tlast;
      check("tvalid_high", axis.tvalid, 1);
      if (rdy) begin
        check("beat_data", axis.tdata, exp_q[k]);
        check("beat_last", axis.tlast, (k == n - 1));
      end
      tick();
      WR_EN = 1'b0; START = 1'b0;
      if (rdy) k++;
      else begin
        check("stall_data", axis.tdata, hold_d);
        check("stall_last", axis.tlast, hold_l);
      end
      cyc++;
    end
    check("burst_complete", (k == n), 1);
    check("done_pulse", DONE, 1);
    check("tvalid_after", axis.tvalid, 0);
    check("busy_after", BUSY, 0);
    axis.tready = 1'b0;
    if (start_in_done) begin
      START = 1'b1; LENGTH = (AW+1)'(4);
    end
    tick();
    START = 1'b0;
    check("done_one_cycle", DONE, 0);
    check("no_relaunch", axis.tvalid, 0);
  endtask

  initial begin
    ARESETN = 1'b0; START = 1'b0; LENGTH = '0;
    WR_EN = 1'b0; WR_ADDR = '0; WR_DATA = '0;
    axis.tready = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) model_ram[i] = '0;
    #23;
    check("rst_tvalid", axis.tvalid, 0);
    check("rst_tlast", axis.tlast, 0);
    check("rst_tdata", axis.tdata, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    ARESETN = 1'b1;
    tick();

    // Full array load so every later burst has a known payload.
    for (int i = 0; i < int'(DEPTH); i++) write_word(i, $urandom);
    for (int i = 0; i < 4; i++) write_word(i, DW'(i + 100));

    run_burst(4, 0, 0, 0, 0, 0, 0, '0);
    run_burst(4, 1, 0, 0, 0, 0, 0, '0);

    // Zero-length START is ignored.
    START = 1'b1; LENGTH = '0;
    tick();
    START = 1'b0;
    check("len0_tvalid", axis.tvalid, 0);
    check("len0_busy", BUSY, 0);
    tick();
    check("len0_done", DONE, 0);
    check("len0_tvalid2", axis.tvalid, 0);

    // Over-range length clamps to the full array.
    run_burst(127, 2, 0, 0, 0, 0, 0, '0);
    run_burst(int'(DEPTH), 0, 0, 0, 0, 0, 0, '0);
    run_burst(1, 1, 0, 0, 0, 0, 0, '0);

    // Write and START during a burst are dropped; rerun shows old payload.
    run_burst(4, 1, 1, 1, 0, 0, 0, '0);
    run_burst(4, 0, 0, 0, 0, 0, 0, '0);

    // START coincident with DONE is ignored.
    run_burst(3, 0, 0, 0, 1, 0, 0, '0);

    // Write coinciding with START: address 0 streams old, address 2 streams new.
    run_burst(4, 0, 0, 0, 0, 1, 0, 32'hA5A5_0000);
    run_burst(4, 2, 0, 0, 0, 1, 2, 32'h5A5A_0002);
    run_burst(4, 0, 0, 0, 0, 0, 0, '0);

    // Reset after two beats: tvalid drops at once, no DONE, payload kept.
    START = 1'b1; LENGTH = (AW+1)'(8);
    tick();
    START = 1'b0; axis.tready = 1'b1;
    tick();
    tick();
    check("pre_rst_tvalid", axis.tvalid, 1);
    ARESETN = 1'b0;
    #1;
    check("mid_rst_tvalid", axis.tvalid, 0);
    check("mid_rst_done", DONE, 0);
    check("mid_rst_busy", BUSY, 0);
    #2;
    ARESETN = 1'b1;
    axis.tready = 1'b0;
    tick();
    check("post_rst_done", DONE, 0);
    run_burst(4, 0, 0, 0, 0, 0, 0, '0);

    // Randomized idle writes and bursts.
    for (int r = 0; r < 8; r++) begin
      int nw;
      nw = $urandom_range(1, 8);
      for (int w = 0; w < nw; w++) write_word($urandom_range(0, DEPTH - 1), $urandom);
      run_burst($urandom_range(1, 2 * DEPTH - 1), $urandom_range(0, 2), 0, 0, 0, 0, 0, '0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
